datamem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port 16-bit word-addressed data memory between NUM_REQ requesters (e.g. core load/store unit, DMA/debug port).
- Registers one memory command per cycle onto the memory's address/enable/data pins and captures combinational read data into a response register.
- Sits between the requesters and the data memory instance; it is the only driver of the memory pins.

---
 rtl/datamem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_datamem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter and command sequencer in front of a single-port word-addressed data memory.
// Define DATAMEM_ARB_CLEAR_EN to zero the whole memory with a write sweep after every reset.
module datamem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         mem_address,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [DW-1:0]         mem_write_data,
    input  logic [DW-1:0]         mem_read_data,
    output logic                  busy
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [PW:0]   NREQ_W   = PW1'(NUM_REQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    logic [AW-1:0] addr_arr  [NUM_REQ];
    logic [DW-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]      mem_address_q, mem_address_d;
    logic [DW-1:0]      mem_write_data_q, mem_write_data_d;
    logic               mem_write_enable_q, mem_write_enable_d;
    logic               mem_read_enable_q, mem_read_enable_d;
    logic [PW-1:0]      tag_q, tag_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    logic               arb_en;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt_vec;

`ifdef DATAMEM_ARB_CLEAR_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // Grants are also masked while reset is held so nothing looks accepted in a reset cycle.
    assign arb_en = reset && (state_q == ST_RUN);
    assign busy   = (state_q == ST_INIT);
`else
    assign arb_en = reset;
    assign busy   = 1'b0;
`endif

    // Rotating priority search starting at rr_ptr_q; the first requester found wins.
    always_comb begin
        logic [PW:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + PW1'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (arb_en && !gnt_any && req[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d           = rr_ptr_q;
        mem_address_d      = mem_address_q;
        mem_write_data_d   = mem_write_data_q;
        mem_write_enable_d = 1'b0;
        mem_read_enable_d  = 1'b0;
        tag_d              = tag_q;
        if (gnt_any) begin
            rr_ptr_d           = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            mem_address_d      = addr_arr[gnt_idx];
            mem_write_data_d   = wdata_arr[gnt_idx];
            mem_write_enable_d = we[gnt_idx];
            mem_read_enable_d  = ~we[gnt_idx];
            tag_d              = gnt_idx;
        end
`ifdef DATAMEM_ARB_CLEAR_EN
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            mem_address_d      = clr_cnt_q;
            mem_write_data_d   = '0;
            mem_write_enable_d = 1'b1;
            mem_read_enable_d  = 1'b0;
            clr_cnt_d          = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_RUN;
            end
        end
`endif
    end

    // Memory read data is combinational off the registered address, so it is captured one edge later.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (mem_read_enable_q) begin
            rvalid_d[tag_q] = 1'b1;
            rdata_d         = mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q           <= '0;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
            mem_read_enable_q  <= 1'b0;
            tag_q              <= '0;
            rvalid_q           <= '0;
            rdata_q            <= '0;
`ifdef DATAMEM_ARB_CLEAR_EN
            state_q            <= ST_INIT;
            clr_cnt_q          <= '0;
`endif
        end else begin
            rr_ptr_q           <= rr_ptr_d;
            mem_address_q      <= mem_address_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_write_enable_q <= mem_write_enable_d;
            mem_read_enable_q  <= mem_read_enable_d;
            tag_q              <= tag_d;
            rvalid_q           <= rvalid_d;
            rdata_q            <= rdata_d;
`ifdef DATAMEM_ARB_CLEAR_EN
            state_q            <= state_d;
            clr_cnt_q          <= clr_cnt_d;
`endif
        end
    end

    assign gnt              = gnt_vec;
    assign rvalid           = rvalid_q;
    assign rdata            = rdata_q;
    assign mem_address      = mem_address_q;
    assign mem_write_enable = mem_write_enable_q;
    assign mem_read_enable  = mem_read_enable_q;
    assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard bench for datamem_arbiter: the driver queues expected memory commands and read
// responses, and a negedge monitor pops and compares them as the DUT presents them.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic [15:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic        busy;

    datamem_arbiter #(.NUM_REQ(2), .AW(16), .DW(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge.
    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hA5A5;
    end
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [15:0] d;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mc;
    rsp_t mr;

    int tests = 0;
    int fails = 0;
    bit sweep_mode = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!sweep_mode && (mem_write_enable || mem_read_enable)) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
            end else begin
                mc = cmd_q.pop_front();
                chk("cmd_cycle", cyc, mc.cyc);
                chk("cmd_we", {31'd0, mem_write_enable}, {31'd0, mc.we});
                chk("cmd_re", {31'd0, mem_read_enable}, {31'd0, ~mc.we});
                chk("cmd_addr", {16'd0, mem_address}, {16'd0, mc.a});
                chk("cmd_wdata", {16'd0, mem_write_data}, {16'd0, mc.d});
            end
        end
        if (rvalid != 2'b00) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rvalid}, 32'd0);
            end else begin
                mr = rsp_q.pop_front();
                chk("rsp_cycle", cyc, mr.cyc);
                chk("rvalid", {30'd0, rvalid}, {30'd0, mr.id});
                chk("rdata", {16'd0, rdata}, {16'd0, mr.d});
            end
        end
    end

    // Drive one cycle of requests, check the grant, and queue what must follow from it.
    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] d0,
                         input logic [15:0] a1, input logic [15:0] d1,
                         input logic [1:0] eg, input logic [15:0] erd);
        int   k;
        cmd_t c;
        rsp_t rr;
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #3;
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        if (eg != 2'b00) begin
            k     = eg[1] ? 1 : 0;
            c.cyc = cyc + 1;
            c.we  = w[k];
            c.a   = (k == 1) ? a1 : a0;
            c.d   = (k == 1) ? d1 : d0;
            cmd_q.push_back(c);
            if (!w[k]) begin
                rr.cyc = cyc + 2;
                rr.id  = eg;
                rr.d   = erd;
                rsp_q.push_back(rr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 16'h0);
    endtask

    logic [15:0] n0;
    logic [15:0] n1;
    logic [1:0]  eg;
    int          nb;
    int          bad;
    cmd_t        mcmd;

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req = 2'b01;
        #3;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_read_enable}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_address}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_write_data}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
`ifdef DATAMEM_ARB_CLEAR_EN
        chk("rst_busy", {31'd0, busy}, 32'd1);
`else
        chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
        @(posedge clk);
        #1;
        req   = 2'b00;
        reset = 1'b1;

`ifdef DATAMEM_ARB_CLEAR_EN
        // Clear sweep: req[0] held for a read of 0xFFFF must not be granted while busy.
        sweep_mode = 1'b1;
        nb  = 0;
        bad = 0;
        while (busy && nb < 70000) begin
            req  = 2'b01;
            we   = 2'b00;
            addr = {16'h0000, 16'hFFFF};
            #3;
            if (gnt != 2'b00) bad++;
            nb++;
            @(posedge clk);
            #1;
        end
        req = 2'b00;
        chk("clr_busy_cycles", nb, 32'd65536);
        chk("clr_no_gnt", bad, 32'd0);
        idle(1);
        sweep_mode = 1'b0;
        drive(2'b10, 2'b00, 16'h0, 16'h0, 16'hFFFF, 16'h0, 2'b10, 16'h0000);
        idle(2);
`endif

        // Single write from requester 0, then read it back from requester 1.
        drive(2'b01, 2'b01, 16'h0010, 16'hBEEF, 16'h0, 16'h0, 2'b01, 16'h0);
        idle(1);
        drive(2'b10, 2'b00, 16'h0, 16'h0, 16'h0010, 16'h0, 2'b10, 16'hBEEF);
        idle(2);

        // Both requesters held: grants alternate starting from requester 0.
        n0 = 16'd0;
        n1 = 16'd0;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            drive(2'b11, 2'b11, 16'h0020 + n0, 16'h1000 + n0, 16'h0030 + n1, 16'h2000 + n1, eg, 16'h0);
            if (eg[0]) n0 = n0 + 16'd1;
            else       n1 = n1 + 16'd1;
        end
        n0 = 16'd0;
        n1 = 16'd0;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            drive(2'b11, 2'b00, 16'h0020 + n0, 16'h0, 16'h0030 + n1, 16'h0, eg,
                  eg[0] ? (16'h1000 + n0) : (16'h2000 + n1));
            if (eg[0]) n0 = n0 + 16'd1;
            else       n1 = n1 + 16'd1;
        end
        idle(2);

        // Read granted the cycle right after a write to the same address sees the new data.
        drive(2'b01, 2'b01, 16'h00FF, 16'h1234, 16'h0, 16'h0, 2'b01, 16'h0);
        drive(2'b10, 2'b00, 16'h0, 16'h0, 16'h00FF, 16'h0, 2'b10, 16'h1234);
        idle(3);
        #3;
        chk("rdata_hold_rvalid", {30'd0, rvalid}, 32'd0);
        chk("rdata_hold", {16'd0, rdata}, 32'h1234);
        @(posedge clk);
        #1;

`ifndef DATAMEM_ARB_CLEAR_EN
        // Reset the cycle after a read grant: the response must vanish and rr_ptr return to 0.
        req  = 2'b01;
        we   = 2'b00;
        addr = {16'h0000, 16'h0010};
        #3;
        chk("mid_gnt", {30'd0, gnt}, 32'd1);
        mcmd.cyc = cyc + 1;
        mcmd.we  = 1'b0;
        mcmd.a   = 16'h0010;
        mcmd.d   = 16'h0000;
        cmd_q.push_back(mcmd);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 2'b11;
        #3;
        chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        @(posedge clk);
        #1;
        req = 2'b00;
        #3;
        chk("mid_rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("mid_rst_re", {31'd0, mem_read_enable}, 32'd0);
        chk("mid_rst_rdata", {16'd0, rdata}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(2'b11, 2'b11, 16'h0040, 16'h4040, 16'h0041, 16'h4141, 2'b01, 16'h0);
        drive(2'b10, 2'b11, 16'h0040, 16'h4040, 16'h0041, 16'h4141, 2'b10, 16'h0);
        drive(2'b01, 2'b00, 16'h0041, 16'h0, 16'h0, 16'h0, 2'b01, 16'h4141);
        idle(3);
`endif

        idle(2);
        chk("cmd_queue_drained", cmd_q.size(), 32'd0);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
